// File: rtl/spi_transfer_arbiter.sv
// spi_transfer_arbiter: round-robin sharing of one SPI engine among several command sources
module spi_transfer_arbiter #(
    parameter int N_REQUESTERS   = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int GW = $clog2(N_REQUESTERS < 2 ? 2 : N_REQUESTERS)
) (
    input  logic                                   clock_i,
    input  logic                                   reset_i,
    input  logic [N_REQUESTERS-1:0]                req_valid_i,
    input  logic [N_REQUESTERS-1:0][DATA_WIDTH-1:0] req_data_i,
    output logic [N_REQUESTERS-1:0]                req_ready_o,
    output logic                                   spi_valid_o,
    output logic [DATA_WIDTH-1:0]                  spi_data_o,
    input  logic                                   spi_ready_i,
    input  logic                                   transfer_done_i,
    input  logic [DATA_WIDTH-1:0]                  spi_data_in_i,
    output logic [N_REQUESTERS-1:0]                resp_valid_o,
    output logic [DATA_WIDTH-1:0]                  resp_data_o,
    output logic                                   resp_error_o,
    output logic                                   busy_o,
    output logic [GW-1:0]                          grant_idx_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESPOND} state_e;

    state_e                state_q, state_d;
    logic [GW-1:0]         rr_q, rr_d, grant_q, grant_d, sel;
    logic                  found;
    logic                  spi_valid_q, spi_valid_d, resp_error_q, resp_error_d;
    logic [DATA_WIDTH-1:0] spi_data_q, spi_data_d, resp_data_q, resp_data_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    function automatic logic [GW-1:0] wrap(input int v);
        return GW'(v % N_REQUESTERS);
    endfunction

    // first valid requester at or after rr_q, wrapping; lowest offset wins
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = N_REQUESTERS - 1; i >= 0; i--) begin
            if (req_valid_i[wrap(int'(rr_q) + i)]) begin
                found = 1'b1;
                sel   = wrap(int'(rr_q) + i);
            end
        end
    end

    // next-state, datapath updates and the two one-hot strobes
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        grant_d      = grant_q;
        spi_valid_d  = spi_valid_q;
        spi_data_d   = spi_data_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        cnt_d        = cnt_q;
        req_ready_o  = '0;
        resp_valid_o = '0;
        case (state_q)
            IDLE: begin
                if (found && !reset_i) begin
                    req_ready_o[sel] = 1'b1;
                    grant_d          = sel;
                    spi_valid_d      = 1'b1;
                    spi_data_d       = req_data_i[sel];
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                if (spi_ready_i) begin
                    spi_valid_d = 1'b0;
                    rr_d        = (grant_q == GW'(N_REQUESTERS - 1)) ? '0 : grant_q + 1'b1;
                    cnt_d       = '0;
                    state_d     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (transfer_done_i) begin
                    resp_data_d  = spi_data_in_i;
                    resp_error_d = 1'b0;
                    state_d      = RESPOND;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    resp_data_d  = '0;
                    resp_error_d = 1'b1;
                    state_d      = RESPOND;
                end
            end
            default: begin
                resp_valid_o[grant_q] = 1'b1;
                state_d               = IDLE;
            end
        endcase
    end

    // state register with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            grant_q      <= '0;
            spi_valid_q  <= 1'b0;
            spi_data_q   <= '0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            grant_q      <= grant_d;
            spi_valid_q  <= spi_valid_d;
            spi_data_q   <= spi_data_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            cnt_q        <= cnt_d;
        end
    end

    assign spi_valid_o  = spi_valid_q;
    assign spi_data_o   = spi_data_q;
    assign resp_data_o  = resp_data_q;
    assign resp_error_o = resp_error_q;
    assign busy_o       = state_q != IDLE;
    assign grant_idx_o  = grant_q;
endmodule

// File: tb/tb_spi_transfer_arbiter.sv
// tb_spi_transfer_arbiter: randomized transfers checked against a transaction-level arbiter model
module tb_spi_transfer_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic                   clk, rst;
    logic [N-1:0]           req_valid, req_ready, resp_valid;
    logic [N-1:0][DW-1:0]   req_data;
    logic                   spi_valid, spi_ready, done, resp_error, busy;
    logic [DW-1:0]          spi_data, spi_din, resp_data;
    logic [1:0]             grant_idx;
    int                     n_chk = 0;
    int                     n_fail = 0;
    int                     rr_m = 0;

    spi_transfer_arbiter #(.N_REQUESTERS(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clock_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready), .spi_valid_o(spi_valid), .spi_data_o(spi_data),
        .spi_ready_i(spi_ready), .transfer_done_i(done), .spi_data_in_i(spi_din),
        .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_error_o(resp_error),
        .busy_o(busy), .grant_idx_o(grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int rr);
        for (int i = 0; i < N; i++) if (v[(rr + i) % N]) return (rr + i) % N;
        return -1;
    endfunction

    // one complete transfer; done_at counts cycles spent in WAIT_DONE (>= TO means never)
    task automatic xfer(input logic [N-1:0] v, input logic [DW-1:0] cmd, input logic [DW-1:0] rd,
                        input int rdy_wait, input int done_at, input bit hs_done);
        int g;
        logic [DW-1:0] exp_d;
        bit err;
        g = pick(v, rr_m);
        for (int i = 0; i < N; i++) req_data[i] = $urandom;
        req_data[g] = cmd;
        req_valid = v;
        #1;
        check("req_ready", req_ready, 64'(1) << g);
        check("busy_idle", busy, 0);
        tick();
        check("spi_valid", spi_valid, 1);
        check("spi_data", spi_data, cmd);
        check("grant_idx", grant_idx, g);
        check("busy_issue", busy, 1);
        check("req_ready_issue", req_ready, 0);
        spi_ready = 1'b0;
        for (int i = 0; i < rdy_wait; i++) begin
            tick();
            check("spi_valid_hold", spi_valid, 1);
            check("spi_data_hold", spi_data, cmd);
        end
        spi_ready = 1'b1;
        done = hs_done;
        tick();
        spi_ready = 1'b0;
        done = 1'b0;
        check("spi_valid_drop", spi_valid, 0);
        err = 1'b1;
        exp_d = '0;
        for (int w = 0; w < TO; w++) begin
            spi_din = $urandom;
            if (w == done_at) begin
                spi_din = rd;
                done = 1'b1;
                err = 1'b0;
                exp_d = rd;
                tick();
                done = 1'b0;
                break;
            end
            #1;
            check("resp_valid_wait", resp_valid, 0);
            tick();
        end
        check("resp_valid", resp_valid, 64'(1) << g);
        check("resp_data", resp_data, exp_d);
        check("resp_error", resp_error, err);
        check("busy_resp", busy, 1);
        rr_m = (g + 1) % N;
        req_valid = '0;
        tick();
        check("resp_valid_once", resp_valid, 0);
        check("busy_back", busy, 0);
    endtask

    task automatic idle_done();
        req_valid = '0;
        done = 1'b1;
        tick();
        done = 1'b0;
        check("idle_done_busy", busy, 0);
        check("idle_done_resp", resp_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '1;
        req_data = '0;
        spi_ready = 1'b0;
        done = 1'b0;
        spi_din = '0;
        repeat (3) tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_spi_valid", spi_valid, 0);
        check("rst_spi_data", spi_data, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_error", resp_error, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_idx, 0);
        req_valid = '0;
        rst = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            check("fair_order", pick(4'hF, rr_m), k % N);
            xfer(4'hF, $urandom, $urandom, 0, $urandom_range(0, 6), 1'b0);
        end
        xfer(4'b0100, 32'hA5A5_0001, 32'h1234, 0, 4, 1'b0);
        xfer(4'b1001, $urandom, $urandom, 10, 2, 1'b0);
        xfer(4'b0010, $urandom, $urandom, 1, TO, 1'b0);
        idle_done();
        xfer(4'b0110, $urandom, $urandom, 0, 3, 1'b1);
        xfer(4'b1000, $urandom, 32'hCAFE_F00D, 2, TO - 1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            xfer(4'($urandom_range(1, 15)), $urandom, $urandom, $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0) ? TO : $urandom_range(0, TO - 1), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_done();
        end
        req_valid = 4'b0100;
        #1;
        tick();
        spi_ready = 1'b1;
        tick();
        spi_ready = 1'b0;
        req_valid = '0;
        tick();
        rst = 1'b1;
        done = 1'b1;
        tick();
        done = 1'b0;
        req_valid = '1;
        #1;
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_spi_valid", spi_valid, 0);
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_resp_data", resp_data, 0);
        check("mid_rst_resp_error", resp_error, 0);
        check("mid_rst_grant", grant_idx, 0);
        req_valid = '0;
        rst = 1'b0;
        rr_m = 0;
        tick();
        idle_done();
        xfer(4'b1010, $urandom, $urandom, 0, 1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
